// File: rtl/spi_module_master.sv
// Single-byte SPI master, MSB first, all four CPOL/CPHA modes.
// SCK half-period, SETUP and HOLD each last CLK_DIV system clocks.
module spi_module_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       I_start,
  input  logic [7:0] I_tx_data,
  input  logic       CPOL,
  input  logic       CPHA,
  output logic [7:0] O_rx_data,
  output logic       O_busy,
  output logic       O_done,
  output logic       O_spi_sck,
  output logic       O_spi_cs,
  output logic       O_spi_mosi,
  input  logic       I_spi_miso
);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state, state_nx;
  logic [7:0] div_cnt, div_cnt_nx;
  logic [3:0] edge_cnt, edge_cnt_nx;
  logic [7:0] tx_sr, tx_sr_nx;
  logic [7:0] rx_sr, rx_sr_nx;
  logic       cpha_r, cpha_nx;
  logic [7:0] rx_data_nx;
  logic       busy_nx, done_nx, sck_nx, cs_nx, mosi_nx;
  logic       div_end;
  logic       leading;

  assign div_end = (div_cnt == DIV_LAST);
  // edge_cnt holds the number of toggles already made, so an even count means the next toggle is leading
  assign leading = ~edge_cnt[0];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      div_cnt    <= '0;
      edge_cnt   <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      cpha_r     <= 1'b0;
      O_rx_data  <= 8'h00;
      O_busy     <= 1'b0;
      O_done     <= 1'b0;
      O_spi_sck  <= 1'b0;
      O_spi_cs   <= 1'b0;
      O_spi_mosi <= 1'b0;
    end else begin
      state      <= state_nx;
      div_cnt    <= div_cnt_nx;
      edge_cnt   <= edge_cnt_nx;
      tx_sr      <= tx_sr_nx;
      rx_sr      <= rx_sr_nx;
      cpha_r     <= cpha_nx;
      O_rx_data  <= rx_data_nx;
      O_busy     <= busy_nx;
      O_done     <= done_nx;
      O_spi_sck  <= sck_nx;
      O_spi_cs   <= cs_nx;
      O_spi_mosi <= mosi_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    div_cnt_nx  = div_cnt;
    edge_cnt_nx = edge_cnt;
    tx_sr_nx    = tx_sr;
    rx_sr_nx    = rx_sr;
    cpha_nx     = cpha_r;
    rx_data_nx  = O_rx_data;
    busy_nx     = O_busy;
    done_nx     = 1'b0;
    sck_nx      = O_spi_sck;
    cs_nx       = O_spi_cs;
    mosi_nx     = O_spi_mosi;

    case (state)
      IDLE: begin
        sck_nx  = CPOL;
        cs_nx   = 1'b0;
        busy_nx = 1'b0;
        if (I_start) begin
          tx_sr_nx    = I_tx_data;
          cpha_nx     = CPHA;
          cs_nx       = 1'b1;
          busy_nx     = 1'b1;
          div_cnt_nx  = '0;
          edge_cnt_nx = '0;
          state_nx    = SETUP;
          if (!CPHA) mosi_nx = I_tx_data[7];
        end
      end

      SETUP: begin
        if (div_end) begin
          div_cnt_nx = '0;
          state_nx   = XFER;
        end else begin
          div_cnt_nx = div_cnt + 8'd1;
        end
      end

      XFER: begin
        if (div_end) begin
          div_cnt_nx  = '0;
          sck_nx      = ~O_spi_sck;
          edge_cnt_nx = edge_cnt + 4'd1;
          if (edge_cnt[0] == cpha_r) rx_sr_nx = {rx_sr[6:0], I_spi_miso};
          // CPHA=0 preloads bit 7 at start, so it advances on trailing edges and skips the final one
          if (cpha_r && leading) begin
            mosi_nx  = tx_sr[7];
            tx_sr_nx = {tx_sr[6:0], 1'b0};
          end else if (!cpha_r && !leading && edge_cnt != 4'd15) begin
            mosi_nx  = tx_sr[6];
            tx_sr_nx = {tx_sr[6:0], 1'b0};
          end
          if (edge_cnt == 4'd15) state_nx = HOLD;
        end else begin
          div_cnt_nx = div_cnt + 8'd1;
        end
      end

      HOLD: begin
        if (div_end) begin
          div_cnt_nx  = '0;
          edge_cnt_nx = '0;
          cs_nx       = 1'b0;
          mosi_nx     = 1'b0;
          rx_data_nx  = rx_sr;
          done_nx     = 1'b1;
          busy_nx     = 1'b0;
          state_nx    = IDLE;
        end else begin
          div_cnt_nx = div_cnt + 8'd1;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/spi_module_master.md
Name: spi_module_master

Overview:
Single-byte SPI master that generates SCK, CS, MOSI and samples MISO for the SPI slave interface on the same bus. It sits between a host-side byte handshake (start/busy/done) and the four-wire SPI bus. It supports all four CPOL/CPHA modes, transfers MSB first, and derives SCK from the system clock through a programmable divider.

Parameters:
CLK_DIV, 4, system-clock cycles per SCK half-period; legal range 1..255.

Ports:
CLK  input  1  system clock, 50 MHz, rising edge.
RESET  input  1  asynchronous reset, active-high.
I_start  input  1  request one transfer; accepted only when idle.
I_tx_data  input  8  byte to send; captured when the start is accepted.
CPOL  input  1  SCK idle level; captured when the start is accepted.
CPHA  input  1  0 = sample on leading edge, 1 = sample on trailing edge; captured when the start is accepted.
O_rx_data  output  8  last received byte; valid from the O_done pulse until the next O_done.
O_busy  output  1  high from start acceptance until O_done.
O_done  output  1  one-cycle pulse when a transfer completes.
O_spi_sck  output  1  SPI clock.
O_spi_cs  output  1  chip select, active-high.
O_spi_mosi  output  1  master out, slave in.
I_spi_miso  input  1  master in, slave out.

Behaviour:
- Reset values: O_spi_sck=0, O_spi_cs=0, O_spi_mosi=0, O_busy=0, O_done=0, O_rx_data=8'h00. The state machine goes to IDLE and all counters clear to 0.
- All outputs are registered and driven from CLK.
- States are IDLE, SETUP, XFER and HOLD. Each of SETUP, HOLD and every SCK half-period lasts exactly CLK_DIV cycles.
- IDLE:
  - O_spi_sck follows the live CPOL input; O_spi_cs=0; O_busy=0.
  - When I_start=1 is seen at edge T0, the block captures I_tx_data, CPOL and CPHA, then drives O_spi_cs=1 and O_busy=1 and enters SETUP.
  - If CPHA=0, O_spi_mosi=tx[7] is also driven at T0.
- SETUP: holds SCK at the captured CPOL for CLK_DIV cycles, then enters XFER.
- XFER:
  - The block produces 16 SCK toggles. Toggle k (k=1..16) occurs at edge T0+(k+1)*CLK_DIV. Odd k is a leading edge; even k is a trailing edge.
  - CPHA=0: MISO is sampled into the shift register on leading edges. MOSI advances to the next bit on trailing edges 2,4,...,14; there is no shift on edge 16.
  - CPHA=1: MOSI shifts out tx[7-n] on leading edge 2n+1. MISO is sampled on trailing edges.
  - Sampling stores the I_spi_miso value present at the CLK edge on which SCK toggles. The first bit sampled lands in bit 7.
  - After toggle 16, SCK equals CPOL and the block enters HOLD.
- HOLD: lasts CLK_DIV cycles. At edge T0+18*CLK_DIV it does all of the following together:
  - O_spi_cs=0 and O_spi_mosi=0.
  - O_rx_data is loaded with the shift register.
  - O_done=1 for exactly one cycle.
  - O_busy=0.
  - The state returns to IDLE.
- Latency from start to done is 18*CLK_DIV cycles (72 with the default).
- Start handshake:
  - I_start while O_busy=1 is ignored, not queued.
  - I_start on the same edge as O_done is ignored. The earliest next acceptance is one cycle after O_done, which guarantees CS is low for at least 1 cycle.
- Input stability: changes to I_tx_data, CPOL or CPHA during a transfer have no effect on that transfer.
- Reset mid-transfer: all outputs immediately take their reset values and no O_done is issued. On the next edge in IDLE, SCK returns to CPOL.
- Divider edge case: with CLK_DIV=1, SCK toggles every cycle, for a 25 MHz SCK at 50 MHz CLK.

Test Plan:
- Mode 0, CLK_DIV=4, tx=8'hA5, MISO looped to MOSI -> O_rx_data=8'hA5; O_done at T0+72; exactly 8 SCK rising edges while CS=1; MOSI stable at every rising edge.
- Mode 3 (CPOL=1, CPHA=1), tx=8'h3C, slave model returns 8'hC3 -> O_rx_data=8'hC3; SCK idles high before and after; MOSI sequence 0,0,1,1,1,1,0,0 at rising edges.
- Modes 1 and 2, CLK_DIV=1, tx=8'h81, MISO driven with 8'h7E -> O_rx_data=8'h7E; O_done at T0+18; SCK half-period of 1 cycle.
- I_start held high continuously for 3 transfers -> exactly 3 O_done pulses spaced 73 cycles apart (CLK_DIV=4); CS low for exactly 1 cycle between transfers; a new I_tx_data value presented mid-transfer is ignored.
- RESET asserted at SCK toggle 7 -> CS=0, SCK=0, O_busy=0 within the same cycle; no O_done; the next transfer of 8'h5A completes correctly.
